ws2812_transmitter: RTL

- Serial output engine for the WS2812 LED strip. It is the consumer side of the pixel RAM that the CPU fills through the WS2812 I/O registers at 30h–32h.
- On a start pulse it reads 3 bytes per LED from the RAM read port (stored order R,G,B) and re-orders them to the wire order G,R,B.
- It emits the NRZ one-wire waveform, then holds the line low for the latch/reset period.
- It signals done and returns to idle.

---
 rtl/ws2812_transmitter_if.sv | 37 +++
 rtl/ws2812_transmitter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ws2812_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_transmitter_if
// Description : Control, pixel-RAM read port and serial line of the WS2812
//               transmitter, bundled for master (host) and slave (engine).
// Revision    : 1.0 - initial release
// ============================================================================
interface ws2812_transmitter_if;
    logic       start;
    logic [7:0] number_of_pixel;
    logic [9:0] pixel_addr;
    logic [7:0] pixel_data;
    logic       busy;
    logic       done;
    logic       ws2812_data;

    modport master (
        output start,
        output number_of_pixel,
        output pixel_data,
        input  pixel_addr,
        input  busy,
        input  done,
        input  ws2812_data
    );

    modport slave (
        input  start,
        input  number_of_pixel,
        input  pixel_data,
        output pixel_addr,
        output busy,
        output done,
        output ws2812_data
    );
endinterface
`default_nettype wire

// File: rtl/ws2812_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_transmitter
// Description : Reads G,R,B bytes per LED from pixel RAM and drives the
//               WS2812 NRZ one-wire waveform followed by a latch-low period.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_transmitter #(
    parameter int T0H_CYCLES   = 11,
    parameter int T1H_CYCLES   = 22,
    parameter int BIT_CYCLES   = 34,
    parameter int LATCH_CYCLES = 1620
) (
    input  logic                clk,
    input  logic                reset,
    ws2812_transmitter_if.slave bus
);

    localparam int c_BIT_CNT_W   = $clog2(BIT_CYCLES + 1);
    localparam int c_LATCH_CNT_W = $clog2(LATCH_CYCLES + 1);

    localparam logic [c_BIT_CNT_W-1:0]   c_T0H         = c_BIT_CNT_W'(T0H_CYCLES);
    localparam logic [c_BIT_CNT_W-1:0]   c_T1H         = c_BIT_CNT_W'(T1H_CYCLES);
    localparam logic [c_BIT_CNT_W-1:0]   c_BIT_LAST    = c_BIT_CNT_W'(BIT_CYCLES - 1);
    localparam logic [c_BIT_CNT_W-1:0]   c_CAPTURE_CNT = c_BIT_CNT_W'(2);
    localparam logic [c_LATCH_CNT_W-1:0] c_LATCH_LAST  = c_LATCH_CNT_W'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    state_t                   r_state;
    logic [7:0]               r_count;
    logic [7:0]               r_led_idx;
    logic [9:0]               r_led_base;
    logic [1:0]               r_byte_sel;
    logic                     r_fetch_phase;
    logic [7:0]               r_shift;
    logic [7:0]               r_next_byte;
    logic [2:0]               r_bit_idx;
    logic [c_BIT_CNT_W-1:0]   r_bit_cnt;
    logic [c_LATCH_CNT_W-1:0] r_latch_cnt;
    logic [9:0]               r_addr;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_ws;

    logic                     w_last_byte;
    logic [1:0]               w_nxt_sel;
    logic [9:0]               w_nxt_base;
    logic [9:0]               w_nxt_addr;
    logic                     w_cnt_end;
    logic [c_BIT_CNT_W-1:0]   w_cnt_nxt;
    logic [7:0]               w_shift_nxt;
    logic                     w_high_nxt;
    logic                     w_first_high;

    // Stored order is R,G,B; the wire wants G,R,B.
    function automatic logic [9:0] f_offset(input logic [1:0] sel);
        case (sel)
            2'd0:    f_offset = 10'd1;
            2'd1:    f_offset = 10'd0;
            default: f_offset = 10'd2;
        endcase
    endfunction

    always_comb begin
        w_last_byte = (r_byte_sel == 2'd2) && (r_led_idx == (r_count - 8'd1));
        w_nxt_sel   = (r_byte_sel == 2'd2) ? 2'd0 : (r_byte_sel + 2'd1);
        w_nxt_base  = (r_byte_sel == 2'd2) ? (r_led_base + 10'd3) : r_led_base;
        w_nxt_addr  = w_nxt_base + f_offset(w_nxt_sel);
        w_cnt_end   = (r_bit_cnt == c_BIT_LAST);
        w_cnt_nxt   = w_cnt_end ? '0 : (r_bit_cnt + c_BIT_CNT_W'(1));

        w_shift_nxt = r_shift;
        if (w_cnt_end) begin
            w_shift_nxt = (r_bit_idx == 3'd0) ? r_next_byte : {r_shift[6:0], 1'b0};
        end
        w_high_nxt   = (w_cnt_nxt < (w_shift_nxt[7] ? c_T1H : c_T0H));
        w_first_high = ((bus.pixel_data[7] ? c_T1H : c_T0H) != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_led_idx     <= '0;
            r_led_base    <= '0;
            r_byte_sel    <= '0;
            r_fetch_phase <= 1'b0;
            r_shift       <= '0;
            r_next_byte   <= '0;
            r_bit_idx     <= '0;
            r_bit_cnt     <= '0;
            r_latch_cnt   <= '0;
            r_addr        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_ws          <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && (bus.number_of_pixel != 8'd0)) begin
                        r_count       <= bus.number_of_pixel;
                        r_led_idx     <= '0;
                        r_led_base    <= '0;
                        r_byte_sel    <= '0;
                        r_addr        <= f_offset(2'd0);
                        r_fetch_phase <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (!r_fetch_phase) begin
                        r_fetch_phase <= 1'b1;
                    end else begin
                        r_fetch_phase <= 1'b0;
                        r_shift       <= bus.pixel_data;
                        r_bit_idx     <= 3'd7;
                        r_bit_cnt     <= '0;
                        r_ws          <= w_first_high;
                        r_state       <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // Prefetch: address in bit-7 count 0, RAM answers during count 1.
                    if ((r_bit_idx == 3'd7) && (r_bit_cnt == '0) && !w_last_byte) begin
                        r_addr <= w_nxt_addr;
                    end
                    if ((r_bit_idx == 3'd7) && (r_bit_cnt == c_CAPTURE_CNT)) begin
                        r_next_byte <= bus.pixel_data;
                    end

                    if (w_cnt_end && (r_bit_idx == 3'd0) && w_last_byte) begin
                        r_ws        <= 1'b0;
                        r_bit_cnt   <= '0;
                        r_latch_cnt <= '0;
                        r_state     <= ST_LATCH;
                    end else begin
                        r_bit_cnt <= w_cnt_nxt;
                        r_shift   <= w_shift_nxt;
                        r_ws      <= w_high_nxt;
                        if (w_cnt_end) begin
                            // 3-bit wrap takes bit 0 back to 7 on a byte advance.
                            r_bit_idx <= r_bit_idx - 3'd1;
                            if (r_bit_idx == 3'd0) begin
                                r_byte_sel <= w_nxt_sel;
                                r_led_base <= w_nxt_base;
                                if (r_byte_sel == 2'd2) begin
                                    r_led_idx <= r_led_idx + 8'd1;
                                end
                            end
                        end
                    end
                end

                ST_LATCH: begin
                    if (r_latch_cnt == c_LATCH_LAST) begin
                        r_latch_cnt <= '0;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_latch_cnt <= r_latch_cnt + c_LATCH_CNT_W'(1);
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.pixel_addr  = r_addr;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.ws2812_data = r_ws;

endmodule
`default_nettype wire
